// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encodings, frame width and default line parameters for the UART receiver
package uart_rx_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;
  localparam int FRAME_BITS      = 8;
  localparam int DEF_CLK_FREQ_HZ = 12_000_000;
  localparam int DEF_BAUD        = 115_200;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte valid/ready buffer plus status pulses between receiver and consumer
interface uart_rx_if;
  import uart_rx_pkg::*;
  logic [FRAME_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic frame_err;
  logic overrun;
  logic busy;
  modport master(output rx_data, rx_valid, frame_err, overrun, busy, input rx_ready);
  modport slave(input rx_data, rx_valid, frame_err, overrun, busy, output rx_ready);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// uart_rx_sync_2ff: two-flop synchroniser with a configurable reset value
module uart_rx_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= {RST_VAL, RST_VAL};
    else     {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, framing/overrun pulses and a 1-deep output buffer
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int BAUD        = DEF_BAUD
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  uart_rx_if.master rx
);
  localparam int CPB = CLK_FREQ_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  logic rxd_s;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [FRAME_BITS-1:0] shift;
  logic tick, stop_ok, stop_bad;
  uart_rx_sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rxd_s));
  assign tick     = cnt == '0;
  assign stop_ok  = state == S_STOP && tick && rxd_s;
  assign stop_bad = state == S_STOP && tick && !rxd_s;
  assign rx.busy  = state != S_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx.rx_data   <= '0;
      rx.rx_valid  <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;
    end else begin
      rx.frame_err <= stop_bad;
      rx.overrun   <= stop_ok && rx.rx_valid && !rx.rx_ready;
      if (stop_ok && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data  <= shift;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;
      case (state)
        S_IDLE:
          if (!rxd_s) begin
            state <= S_START;
            cnt   <= CW'(CPB / 2 - 1);
          end
        S_START:
          if (!tick) cnt <= cnt - CW'(1);
          else if (rxd_s) state <= S_IDLE;
          else begin
            state   <= S_DATA;
            cnt     <= CW'(CPB - 1);
            bit_idx <= '0;
          end
        S_DATA:
          if (!tick) cnt <= cnt - CW'(1);
          else begin
            shift   <= {rxd_s, shift[FRAME_BITS-1:1]};
            cnt     <= CW'(CPB - 1);
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
        S_STOP:
          if (!tick) cnt <= cnt - CW'(1);
          else state <= rxd_s ? S_IDLE : S_BREAK;
        S_BREAK: if (rxd_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios for uart_rx at 10 clocks per bit
`timescale 1ns/1ps
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  int checks = 0;
  int errs = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rise_cnt = 0;
  int vcyc = 0;
  logic [7:0] vals [0:3];
  logic prev_valid = 1'b0;

  uart_rx_if ifc();
  uart_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx(ifc.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.frame_err) fe_cnt++;
      if (ifc.overrun) ov_cnt++;
      if (ifc.rx_valid) vcyc++;
      if (ifc.rx_valid && !prev_valid) begin
        if (rise_cnt < 4) vals[rise_cnt] = ifc.rx_data;
        rise_cnt++;
      end
    end
    prev_valid = ifc.rx_valid;
  end

  task automatic clear_counts();
    fe_cnt = 0; ov_cnt = 0; rise_cnt = 0; vcyc = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk) rxd = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (10) @(negedge clk);
    end
    rxd = stop;
    repeat (10) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic consume(input logic [7:0] exp_data);
    @(negedge clk) ifc.rx_ready = 1'b1;
    @(negedge clk) ifc.rx_ready = 1'b0;
    checks++;
    if (ifc.rx_valid !== 1'b0) begin errs++; $display("FAIL consume_valid got=%b exp=0", ifc.rx_valid); end
    checks++;
    if (ifc.rx_data !== exp_data) begin errs++; $display("FAIL consume_data got=%h exp=%h", ifc.rx_data, exp_data); end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ifc.rx_valid, ifc.frame_err, ifc.overrun, ifc.busy} !== 4'b0) begin
      errs++; $display("FAIL reset_flags got=%b exp=0000", {ifc.rx_valid, ifc.frame_err, ifc.overrun, ifc.busy});
    end
    checks++;
    if (ifc.rx_data !== 8'h00) begin errs++; $display("FAIL reset_data got=%h exp=00", ifc.rx_data); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    clear_counts();
    send_frame(8'h55, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.rx_valid !== 1'b1) begin errs++; $display("FAIL single_valid got=%b exp=1", ifc.rx_valid); end
    checks++;
    if (ifc.rx_data !== 8'h55) begin errs++; $display("FAIL single_data got=%h exp=55", ifc.rx_data); end
    checks++;
    if (fe_cnt !== 0) begin errs++; $display("FAIL single_frame_err got=%0d exp=0", fe_cnt); end
    checks++;
    if (ifc.busy !== 1'b0) begin errs++; $display("FAIL single_busy got=%b exp=0", ifc.busy); end
    consume(8'h55);
  endtask

  task automatic test_glitch();
    clear_counts();
    @(negedge clk) rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    checks++;
    if (ifc.busy !== 1'b1) begin errs++; $display("FAIL glitch_start_busy got=%b exp=1", ifc.busy); end
    repeat (8) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0) begin errs++; $display("FAIL glitch_idle got=%b exp=0", ifc.busy); end
    checks++;
    if (rise_cnt !== 0 || fe_cnt !== 0) begin
      errs++; $display("FAIL glitch_flags valid=%0d ferr=%0d exp=0/0", rise_cnt, fe_cnt);
    end
  endtask

  task automatic test_break();
    clear_counts();
    send_frame(8'hA5, 1'b0);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b1) begin errs++; $display("FAIL break_busy got=%b exp=1", ifc.busy); end
    checks++;
    if (fe_cnt !== 1) begin errs++; $display("FAIL break_frame_err got=%0d exp=1", fe_cnt); end
    checks++;
    if (rise_cnt !== 0) begin errs++; $display("FAIL break_no_valid got=%0d exp=0", rise_cnt); end
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0) begin errs++; $display("FAIL break_release got=%b exp=0", ifc.busy); end
    send_frame(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (rise_cnt !== 1 || vals[0] !== 8'h3C) begin
      errs++; $display("FAIL break_next got=%0d/%h exp=1/3c", rise_cnt, vals[0]);
    end
    checks++;
    if (fe_cnt !== 1) begin errs++; $display("FAIL break_single_pulse got=%0d exp=1", fe_cnt); end
    consume(8'h3C);
  endtask

  task automatic test_overrun();
    clear_counts();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (ov_cnt !== 1) begin errs++; $display("FAIL overrun_pulse got=%0d exp=1", ov_cnt); end
    checks++;
    if (ifc.rx_data !== 8'h11 || ifc.rx_valid !== 1'b1) begin
      errs++; $display("FAIL overrun_keep got=%h/%b exp=11/1", ifc.rx_data, ifc.rx_valid);
    end
    consume(8'h11);
  endtask

  task automatic test_back_to_back();
    @(negedge clk) ifc.rx_ready = 1'b1;
    clear_counts();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (3) @(negedge clk);
    ifc.rx_ready = 1'b0;
    checks++;
    if (vcyc !== 2 || rise_cnt !== 2) begin
      errs++; $display("FAIL b2b_pulses got=%0d cycles/%0d rises exp=2/2", vcyc, rise_cnt);
    end
    checks++;
    if (vals[0] !== 8'h11 || vals[1] !== 8'h22) begin
      errs++; $display("FAIL b2b_data got=%h,%h exp=11,22", vals[0], vals[1]);
    end
    checks++;
    if (ov_cnt !== 0) begin errs++; $display("FAIL b2b_overrun got=%0d exp=0", ov_cnt); end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk) rxd = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      repeat (10) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ifc.rx_valid, ifc.busy, ifc.frame_err, ifc.overrun} !== 4'b0) begin
      errs++; $display("FAIL midreset_flags got=%b exp=0000", {ifc.rx_valid, ifc.busy, ifc.frame_err, ifc.overrun});
    end
    checks++;
    if (ifc.rx_data !== 8'h00) begin errs++; $display("FAIL midreset_data got=%h exp=00", ifc.rx_data); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clear_counts();
    send_frame(8'h81, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.rx_valid !== 1'b1 || ifc.rx_data !== 8'h81) begin
      errs++; $display("FAIL midreset_recover got=%b/%h exp=1/81", ifc.rx_valid, ifc.rx_data);
    end
  endtask

  initial begin
    ifc.rx_ready = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
